// File: rtl/or1200_wb_writer_pkg.sv
// Shared constants and types for the OR1200 write-back writer.
// These are the result source-select encodings, the link offset and the WB FSM state type.
package or1200_wb_writer_pkg;

    localparam logic [2:0] SEL_ALU  = 3'd0;
    localparam logic [2:0] SEL_LSU  = 3'd1;
    localparam logic [2:0] SEL_SPRS = 3'd2;
    localparam logic [2:0] SEL_LINK = 3'd3;
    localparam logic [2:0] SEL_MAC  = 3'd4;

    // A link result is the address of the instruction after the delay slot.
    localparam logic [31:0] LINK_OFFSET = 32'd8;

    typedef enum logic [1:0] {
        WB_IDLE  = 2'd0,
        WB_WRITE = 2'd1,
        WB_HELD  = 2'd2
    } wb_state_t;

endpackage

// File: rtl/or1200_wb_writer_srcmux.sv
// EX result source selector (module or1200_wb_srcmux), purely combinational.
// Define OR1200_WB_MAC_SEL_EN to enable the MAC result source; otherwise source 4 decodes as ALU.
module or1200_wb_srcmux
    import or1200_wb_writer_pkg::*;
#(
    parameter int width = 32
) (
    input  logic [2:0]       sel,
    input  logic [width-1:0] alu_dataout,
    input  logic [width-1:0] lsu_dataout,
    input  logic [width-1:0] sprs_dataout,
    input  logic [width-1:0] mac_dataout,
    input  logic [31:0]      ex_pc,
    output logic [width-1:0] ex_forw
);

    logic [31:0] link_addr;

    assign link_addr = ex_pc + LINK_OFFSET;

    always_comb begin
        ex_forw = alu_dataout;
        case (sel)
            SEL_ALU:  ex_forw = alu_dataout;
            SEL_LSU:  ex_forw = lsu_dataout;
            SEL_SPRS: ex_forw = sprs_dataout;
            SEL_LINK: ex_forw = width'(link_addr);
`ifdef OR1200_WB_MAC_SEL_EN
            SEL_MAC:  ex_forw = mac_dataout;
`endif
            default:  ex_forw = alu_dataout;
        endcase
    end

`ifndef OR1200_WB_MAC_SEL_EN
    // MAC result is deliberately dropped in this build.
    logic unused_mac;
    assign unused_mac = ^mac_dataout;
`endif

endmodule

// File: rtl/or1200_wb_writer.sv
// OR1200 write-back stage: WB result register plus an FSM that issues exactly one register-file write per instruction.
// Build option OR1200_WB_MAC_SEL_EN (see or1200_wb_srcmux) enables the MAC result source.
module or1200_wb_writer
    import or1200_wb_writer_pkg::*;
#(
    parameter int width = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ex_freeze,
    input  logic             wb_freeze,
    input  logic [3:0]       rfwb_op,
    input  logic [4:0]       rf_addrw_ex,
    input  logic [width-1:0] alu_dataout,
    input  logic [width-1:0] lsu_dataout,
    input  logic [width-1:0] sprs_dataout,
    input  logic [width-1:0] mac_dataout,
    input  logic [31:0]      ex_pc,
    output logic [width-1:0] ex_forw,
    output logic [width-1:0] wb_forw,
    output logic             rf_we,
    output logic [4:0]       rf_addrw,
    output logic [width-1:0] rf_dataw,
    output logic             wb_valid
);

    wb_state_t state, state_next;
    logic      capture_valid;

    or1200_wb_srcmux #(.width(width)) u_srcmux (
        .sel          (rfwb_op[3:1]),
        .alu_dataout  (alu_dataout),
        .lsu_dataout  (lsu_dataout),
        .sprs_dataout (sprs_dataout),
        .mac_dataout  (mac_dataout),
        .ex_pc        (ex_pc),
        .ex_forw      (ex_forw)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wb_forw  <= '0;
            rf_addrw <= '0;
            state    <= WB_IDLE;
        end else begin
            if (!wb_freeze && !ex_freeze) begin
                wb_forw  <= ex_forw;
                rf_addrw <= rf_addrw_ex;
            end
            state <= state_next;
        end
    end

    // A frozen EX stage injects a bubble; a frozen WB stage keeps whatever is there.
    always_comb begin
        capture_valid = !ex_freeze && rfwb_op[0];
        state_next    = state;
        if (!wb_freeze)
            state_next = capture_valid ? WB_WRITE : WB_IDLE;
        else if (state == WB_WRITE)
            state_next = WB_HELD;
    end

    assign wb_valid = (state != WB_IDLE);
    assign rf_we    = (state == WB_WRITE) && (rf_addrw != 5'd0);
    assign rf_dataw = wb_forw;

endmodule
